// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall-vector encodings,
// FSM state type and the source/destination match helper.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_WIDTH = 6;

    // Bit k holds stage k: [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB
    localparam logic [STALL_WIDTH-1:0] STALL_NONE     = 6'b000000;
    localparam logic [STALL_WIDTH-1:0] STALL_MEM      = 6'b011111;
    localparam logic [STALL_WIDTH-1:0] STALL_EX       = 6'b001111;
    localparam logic [STALL_WIDTH-1:0] STALL_LOAD_USE = 6'b000111;
    localparam logic [STALL_WIDTH-1:0] STALL_HALTED   = 6'b111111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } pipe_state_t;

    function automatic logic src_hazard(input logic       rd_en,
                                        input logic [4:0] rs_addr,
                                        input logic [4:0] rd_addr);
        return rd_en && (rs_addr == rd_addr);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds a source read in ID.
// Kept standalone so forwarding logic can reuse the same match terms later.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       rs1_rd_en_i,
    input  logic       rs2_rd_en_i,
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    input  logic [4:0] rd_addr_i,
    input  logic       mem_read_i,
    output logic       load_use_o
);

    // x0 never carries a real dependency
    always_comb begin
        if (mem_read_i && (rd_addr_i != 5'd0)) begin
            load_use_o = src_hazard(rs1_rd_en_i, rs1_addr_i, rd_addr_i)
                      || src_hazard(rs2_rd_en_i, rs2_addr_i, rd_addr_i);
        end else begin
            load_use_o = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall vector, IF/ID flush and PC redirect,
// halt/drain sequencing, memory-wait watchdog and stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rs1_rd_en_id,
    input  logic                   rs2_rd_en_id,
    input  logic [4:0]             rs1_addr_id,
    input  logic [4:0]             rs2_addr_id,
    input  logic [4:0]             rd_addr_ex,
    input  logic                   mem_read_ex,
    input  logic                   branch_taken_id,
    input  logic [31:0]            branch_addr_id,
    input  logic                   halt_req_id,
    input  logic                   stallreq_ex,
    input  logic                   stallreq_mem,
    input  logic                   resume,
    output logic [STALL_WIDTH-1:0] stall,
    output logic                   flush_if,
    output logic                   pc_redirect,
    output logic [31:0]            pc_target,
    output logic                   halted,
    output logic                   mem_timeout,
    output logic [CNT_WIDTH-1:0]   stall_cnt
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    pipe_state_t            state_q, state_d;
    logic [1:0]             drain_q, drain_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   timeout_q, timeout_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   load_use_s;
    logic                   branch_ok_s;
    logic [STALL_WIDTH-1:0] stall_s;

    hazard_detect u_hazard_detect (
        .rs1_rd_en_i (rs1_rd_en_id),
        .rs2_rd_en_i (rs2_rd_en_id),
        .rs1_addr_i  (rs1_addr_id),
        .rs2_addr_i  (rs2_addr_id),
        .rd_addr_i   (rd_addr_ex),
        .mem_read_i  (mem_read_ex),
        .load_use_o  (load_use_s)
    );

    // While a post-resume flush is pending, ID still holds the EBREAK, so halt/branch are ignored
    always_comb begin
        stall_s     = STALL_NONE;
        branch_ok_s = 1'b0;
        if (rst) begin
            stall_s = STALL_NONE;
        end else if (state_q == HALTED) begin
            stall_s = STALL_HALTED;
        end else if (stallreq_mem) begin
            stall_s = STALL_MEM;
        end else if (stallreq_ex) begin
            stall_s = STALL_EX;
        end else if ((state_q == DRAIN) || load_use_s) begin
            stall_s = STALL_LOAD_USE;
        end else if (halt_req_id && !flush_pend_q) begin
            stall_s = STALL_LOAD_USE;
        end else begin
            branch_ok_s = branch_taken_id && !flush_pend_q;
        end
    end

    assign stall       = stall_s;
    assign pc_redirect = branch_ok_s;
    assign pc_target   = branch_ok_s ? branch_addr_id : 32'h0000_0000;
    assign flush_if    = branch_ok_s || (!rst && flush_pend_q && !stall_s[1]);
    assign halted      = !rst && (state_q == HALTED);
    assign mem_timeout = !rst && timeout_q;
    assign stall_cnt   = rst ? {CNT_WIDTH{1'b0}} : cnt_q;

    // Next-state: FSM, drain counter, watchdog and stall counter
    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        timeout_d    = timeout_q;
        flush_pend_d = flush_pend_q && stall_s[1];
        wd_d         = {WD_W{1'b0}};

        if (stall_s[0] && (state_q != HALTED)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            RUN: begin
                if (stallreq_mem || stallreq_ex) begin
                    state_d = WAIT;
                end else if (halt_req_id && !load_use_s && !flush_pend_q) begin
                    state_d = DRAIN;
                    drain_d = 2'd3;
                end else begin
                    state_d = RUN;
                end
            end
            WAIT: begin
                if (!stallreq_mem && !stallreq_ex) begin
                    state_d = RUN;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                // Counter reaching 1 means the pipe behind ID is empty
                if (stallreq_mem || stallreq_ex) begin
                    drain_d = drain_q;
                end else if (drain_q == 2'd2) begin
                    drain_d = 2'd1;
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            HALTED: begin
                if (resume && !timeout_q) begin
                    state_d      = RUN;
                    flush_pend_d = 1'b1;
                end else begin
                    state_d = HALTED;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (stallreq_mem && (state_q != HALTED)) begin
            if (wd_q == WD_LAST) begin
                timeout_d    = 1'b1;
                state_d      = HALTED;
                flush_pend_d = 1'b0;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end else begin
            wd_d = {WD_W{1'b0}};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            drain_q      <= 2'd0;
            wd_q         <= {WD_W{1'b0}};
            timeout_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            cnt_q        <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rs1_rd_en_id, rs2_rd_en_id;
    logic [4:0]  rs1_addr_id, rs2_addr_id, rd_addr_ex;
    logic        mem_read_ex, branch_taken_id, halt_req_id;
    logic [31:0] branch_addr_id;
    logic        stallreq_ex, stallreq_mem, resume;
    logic [5:0]  stall;
    logic        flush_if, pc_redirect, halted, mem_timeout;
    logic [31:0] pc_target, stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(.TIMEOUT(16), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .rs1_rd_en_id(rs1_rd_en_id), .rs2_rd_en_id(rs2_rd_en_id),
        .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
        .rd_addr_ex(rd_addr_ex), .mem_read_ex(mem_read_ex),
        .branch_taken_id(branch_taken_id), .branch_addr_id(branch_addr_id),
        .halt_req_id(halt_req_id), .stallreq_ex(stallreq_ex),
        .stallreq_mem(stallreq_mem), .resume(resume),
        .stall(stall), .flush_if(flush_if), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .halted(halted), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [5:0] st, input logic fl,
                           input logic rd, input logic [31:0] tg);
        chk({tag, ".stall"}, {26'd0, stall}, {26'd0, st});
        chk({tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, fl});
        chk({tag, ".pc_redirect"}, {31'd0, pc_redirect}, {31'd0, rd});
        chk({tag, ".pc_target"}, pc_target, tg);
    endtask

    task automatic chk_stat(input string tag, input logic h, input logic t, input logic [31:0] c);
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
        chk({tag, ".mem_timeout"}, {31'd0, mem_timeout}, {31'd0, t});
        chk({tag, ".stall_cnt"}, stall_cnt, c);
    endtask

    task automatic idle();
        rs1_rd_en_id = 1'b0; rs2_rd_en_id = 1'b0;
        rs1_addr_id = 5'd0; rs2_addr_id = 5'd0; rd_addr_ex = 5'd0;
        mem_read_ex = 1'b0; branch_taken_id = 1'b0; branch_addr_id = 32'h0;
        halt_req_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0; resume = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        idle();
        // Reset with active requests: everything forced low
        stallreq_mem = 1'b1; branch_taken_id = 1'b1; branch_addr_id = 32'h0000_0040;
        tick(); #1;
        chk_out("rst_active", 6'b000000, 1'b0, 1'b0, 32'h0);
        chk_stat("rst_active", 1'b0, 1'b0, 32'd0);
        tick();
        idle(); rst = 1'b0; #1;
        chk_out("post_rst", 6'b000000, 1'b0, 1'b0, 32'h0);
        chk_stat("post_rst", 1'b0, 1'b0, 32'd0);

        // Load-use on rs2
        mem_read_ex = 1'b1; rd_addr_ex = 5'd5; rs2_rd_en_id = 1'b1; rs2_addr_id = 5'd5; #1;
        chk_out("lu_rs2", 6'b000111, 1'b0, 1'b0, 32'h0);
        tick();
        rd_addr_ex = 5'd0; rs2_addr_id = 5'd0; #1;
        chk_out("lu_x0", 6'b000000, 1'b0, 1'b0, 32'h0);
        rd_addr_ex = 5'd5; rs2_rd_en_id = 1'b0; rs1_addr_id = 5'd5; #1;
        chk_out("lu_no_en", 6'b000000, 1'b0, 1'b0, 32'h0);
        rs1_rd_en_id = 1'b1; #1;
        chk_out("lu_rs1", 6'b000111, 1'b0, 1'b0, 32'h0);
        tick();
        idle(); #1;
        chk_stat("lu_cnt", 1'b0, 1'b0, 32'd2);

        // Branch, then branch blocked by EX stall, then honoured as WAIT drops
        branch_taken_id = 1'b1; branch_addr_id = 32'h0000_0100; #1;
        chk_out("br_taken", 6'b000000, 1'b1, 1'b1, 32'h0000_0100);
        stallreq_ex = 1'b1; #1;
        chk_out("br_ex_stall", 6'b001111, 1'b0, 1'b0, 32'h0);
        tick();
        stallreq_ex = 1'b0; #1;
        chk_out("br_wait_drop", 6'b000000, 1'b1, 1'b1, 32'h0000_0100);
        tick();
        idle(); #1;
        chk_stat("br_cnt", 1'b0, 1'b0, 32'd3);

        // Halt + branch together: halt wins, then 3 cycles at 000111 total
        halt_req_id = 1'b1; branch_taken_id = 1'b1; branch_addr_id = 32'h0000_0200; #1;
        chk_out("halt_br", 6'b000111, 1'b0, 1'b0, 32'h0);
        tick();
        idle(); #1;
        chk_out("drain1", 6'b000111, 1'b0, 1'b0, 32'h0);
        chk_stat("drain1", 1'b0, 1'b0, 32'd4);
        tick();
        chk_out("drain2", 6'b000111, 1'b0, 1'b0, 32'h0);
        tick();
        chk_out("halted", 6'b111111, 1'b0, 1'b0, 32'h0);
        chk_stat("halted", 1'b1, 1'b0, 32'd6);
        tick();
        chk_stat("halted_hold", 1'b1, 1'b0, 32'd6);
        resume = 1'b1; #1;
        chk_out("resume_req", 6'b111111, 1'b0, 1'b0, 32'h0);
        tick();
        resume = 1'b0; halt_req_id = 1'b1; #1;
        chk_out("resume_flush", 6'b000000, 1'b1, 1'b0, 32'h0);
        chk_stat("resume_flush", 1'b0, 1'b0, 32'd6);
        tick();
        idle(); #1;
        chk_out("after_flush", 6'b000000, 1'b0, 1'b0, 32'h0);

        // Memory wait for four cycles
        stallreq_mem = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_out("mem_wait", 6'b011111, 1'b0, 1'b0, 32'h0);
            tick();
        end
        stallreq_mem = 1'b0; #1;
        chk_out("mem_drop", 6'b000000, 1'b0, 1'b0, 32'h0);
        tick();
        chk_stat("mem_cnt", 1'b0, 1'b0, 32'd10);

        // EX stall during DRAIN freezes the drain counter
        halt_req_id = 1'b1; tick();
        halt_req_id = 1'b0; stallreq_ex = 1'b1; #1;
        chk_out("drain_ex", 6'b001111, 1'b0, 1'b0, 32'h0);
        tick();
        stallreq_ex = 1'b0; tick();
        chk_out("drain_frozen", 6'b000111, 1'b0, 1'b0, 32'h0);
        chk_stat("drain_frozen", 1'b0, 1'b0, 32'd13);
        tick();
        chk_stat("drain_halt", 1'b1, 1'b0, 32'd14);

        // Reset from HALTED
        rst = 1'b1; #1;
        chk_out("rst_halted", 6'b000000, 1'b0, 1'b0, 32'h0);
        chk_stat("rst_halted", 1'b0, 1'b0, 32'd0);
        tick();
        rst = 1'b0; #1;
        chk_out("rst_halted_rel", 6'b000000, 1'b0, 1'b0, 32'h0);

        // Reset mid-DRAIN
        halt_req_id = 1'b1; tick();
        halt_req_id = 1'b0; rst = 1'b1; #1;
        chk_out("rst_drain", 6'b000000, 1'b0, 1'b0, 32'h0);
        chk_stat("rst_drain", 1'b0, 1'b0, 32'd0);
        tick();
        rst = 1'b0; #1;
        chk_out("rst_drain_rel", 6'b000000, 1'b0, 1'b0, 32'h0);
        tick();
        chk_out("rst_drain_run", 6'b000000, 1'b0, 1'b0, 32'h0);
        chk_stat("rst_drain_run", 1'b0, 1'b0, 32'd0);

        // Watchdog: 16 consecutive memory-wait cycles abort into HALTED
        stallreq_mem = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk_out("wd_15", 6'b011111, 1'b0, 1'b0, 32'h0);
        chk_stat("wd_15", 1'b0, 1'b0, 32'd15);
        tick();
        chk_out("wd_16", 6'b111111, 1'b0, 1'b0, 32'h0);
        chk_stat("wd_16", 1'b1, 1'b1, 32'd16);
        stallreq_mem = 1'b0; resume = 1'b1; tick();
        resume = 1'b0; #1;
        chk_out("wd_resume", 6'b111111, 1'b0, 1'b0, 32'h0);
        chk_stat("wd_resume", 1'b1, 1'b1, 32'd16);
        rst = 1'b1; tick();
        rst = 1'b0; #1;
        chk_stat("wd_rst", 1'b0, 1'b0, 32'd0);
        chk_out("wd_rst", 6'b000000, 1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
